// File: rtl/torus_sw_alloc.sv
// rtl/torus_sw_alloc.sv - switch allocator and flow control for one torus router (W/N/P in, E/S/X out)
module torus_sw_alloc #(
    parameter int X_W = 3,
    parameter int Y_W = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [X_W-1:0] my_x,
    input  logic [Y_W-1:0] my_y,
    input  logic           w_vld,
    input  logic           n_vld,
    input  logic           p_vld,
    input  logic           w_tail,
    input  logic           n_tail,
    input  logic           p_tail,
    input  logic [X_W-1:0] w_dx,
    input  logic [X_W-1:0] n_dx,
    input  logic [X_W-1:0] p_dx,
    input  logic [Y_W-1:0] w_dy,
    input  logic [Y_W-1:0] n_dy,
    input  logic [Y_W-1:0] p_dy,
    output logic           w_rdy,
    output logic           n_rdy,
    output logic           p_rdy,
    input  logic           e_rdy,
    input  logic           s_rdy,
    input  logic           x_rdy,
    output logic           e_vld,
    output logic           s_vld,
    output logic           x_vld,
    output logic           w2e,
    output logic           p2e,
    output logic           n2s,
    output logic           w2s,
    output logic           p2s,
    output logic           n2x,
    output logic           w2x,
    output logic           err_route,
    output logic           err_self
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        SINK = 2'd2
    } in_state_t;

    in_state_t w_st, n_st, p_st;

    // Dimension-ordered route decode, valid only while the input is IDLE (head flit)
    logic w_to_e, w_to_s, w_to_x;
    logic n_to_s, n_to_x;
    logic p_to_e, p_to_s, p_to_k;

    assign w_to_e = (w_dx != my_x);
    assign w_to_s = !w_to_e && (w_dy != my_y);
    assign w_to_x = !w_to_e && !w_to_s;
    assign n_to_s = (n_dy != my_y);
    assign n_to_x = !n_to_s;
    assign p_to_e = (p_dx != my_x);
    assign p_to_s = !p_to_e && (p_dy != my_y);
    assign p_to_k = !p_to_e && !p_to_s;

    logic w_req, n_req, p_req;
    assign w_req = (w_st == IDLE) && w_vld;
    assign n_req = (n_st == IDLE) && n_vld;
    assign p_req = (p_st == IDLE) && p_vld;

    // Request vectors, indexed in each output's candidate order
    logic [1:0] req_e;
    logic [2:0] req_s;
    logic [1:0] req_x;
    assign req_e = {p_req && p_to_e, w_req && w_to_e};
    assign req_s = {p_req && p_to_s, w_req && w_to_s, n_req && n_to_s};
    assign req_x = {w_req && w_to_x, n_req && n_to_x};

    logic free_e, free_s, free_x;
    assign free_e = !(w2e || p2e);
    assign free_s = !(n2s || w2s || p2s);
    assign free_x = !(n2x || w2x);

    logic       ptr_e;
    logic [1:0] ptr_s;
    logic       ptr_x;
    logic [1:0] gnt_e;
    logic [2:0] gnt_s;
    logic [1:0] gnt_x;

    always_comb begin
        gnt_e = 2'b00;
        if (free_e) begin
            if (ptr_e == 1'b0) begin
                if (req_e[0])      gnt_e = 2'b01;
                else if (req_e[1]) gnt_e = 2'b10;
            end else begin
                if (req_e[1])      gnt_e = 2'b10;
                else if (req_e[0]) gnt_e = 2'b01;
            end
        end
    end

    always_comb begin
        gnt_x = 2'b00;
        if (free_x) begin
            if (ptr_x == 1'b0) begin
                if (req_x[0])      gnt_x = 2'b01;
                else if (req_x[1]) gnt_x = 2'b10;
            end else begin
                if (req_x[1])      gnt_x = 2'b10;
                else if (req_x[0]) gnt_x = 2'b01;
            end
        end
    end

    always_comb begin
        gnt_s = 3'b000;
        if (free_s) begin
            case (ptr_s)
                2'd1: begin
                    if (req_s[1])      gnt_s = 3'b010;
                    else if (req_s[2]) gnt_s = 3'b100;
                    else if (req_s[0]) gnt_s = 3'b001;
                end
                2'd2: begin
                    if (req_s[2])      gnt_s = 3'b100;
                    else if (req_s[0]) gnt_s = 3'b001;
                    else if (req_s[1]) gnt_s = 3'b010;
                end
                default: begin
                    if (req_s[0])      gnt_s = 3'b001;
                    else if (req_s[1]) gnt_s = 3'b010;
                    else if (req_s[2]) gnt_s = 3'b100;
                end
            endcase
        end
    end

    // Payload handshake passes straight through the owned output
    assign w_rdy = (w2e && e_rdy) || (w2s && s_rdy) || (w2x && x_rdy);
    assign n_rdy = (n2s && s_rdy) || (n2x && x_rdy);
    assign p_rdy = (p2e && e_rdy) || (p2s && s_rdy) || (p_st == SINK);
    assign e_vld = (w2e && w_vld) || (p2e && p_vld);
    assign s_vld = (n2s && n_vld) || (w2s && w_vld) || (p2s && p_vld);
    assign x_vld = (n2x && n_vld) || (w2x && w_vld);

    logic w_done, n_done, p_done;
    assign w_done = w_vld && w_rdy && w_tail;
    assign n_done = n_vld && n_rdy && n_tail;
    assign p_done = p_vld && p_rdy && p_tail;

    logic w_gnt, n_gnt, p_gnt, p_sink;
    assign w_gnt  = gnt_e[0] || gnt_s[1] || gnt_x[1];
    assign n_gnt  = gnt_s[0] || gnt_x[0];
    assign p_gnt  = gnt_e[1] || gnt_s[2];
    assign p_sink = p_req && p_to_k;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_st      <= IDLE;
            n_st      <= IDLE;
            p_st      <= IDLE;
            ptr_e     <= 1'b0;
            ptr_s     <= 2'd0;
            ptr_x     <= 1'b0;
            w2e       <= 1'b0;
            p2e       <= 1'b0;
            n2s       <= 1'b0;
            w2s       <= 1'b0;
            p2s       <= 1'b0;
            n2x       <= 1'b0;
            w2x       <= 1'b0;
            err_route <= 1'b0;
            err_self  <= 1'b0;
        end else begin
            case (w_st)
                IDLE:    if (w_gnt) w_st <= XFER;
                XFER:    if (w_done) w_st <= IDLE;
                default: w_st <= IDLE;
            endcase
            case (n_st)
                IDLE:    if (n_gnt) n_st <= XFER;
                XFER:    if (n_done) n_st <= IDLE;
                default: n_st <= IDLE;
            endcase
            case (p_st)
                IDLE: begin
                    if (p_gnt)       p_st <= XFER;
                    else if (p_sink) p_st <= SINK;
                end
                XFER:    if (p_done) p_st <= IDLE;
                SINK:    if (p_done) p_st <= IDLE;
                default: p_st <= IDLE;
            endcase

            // Selects double as the output lock: set on grant, dropped as the tail leaves
            w2e <= gnt_e[0] || (w2e && !w_done);
            p2e <= gnt_e[1] || (p2e && !p_done);
            n2s <= gnt_s[0] || (n2s && !n_done);
            w2s <= gnt_s[1] || (w2s && !w_done);
            p2s <= gnt_s[2] || (p2s && !p_done);
            n2x <= gnt_x[0] || (n2x && !n_done);
            w2x <= gnt_x[1] || (w2x && !w_done);

            if (gnt_e != 2'b00) ptr_e <= gnt_e[0];
            if (gnt_x != 2'b00) ptr_x <= gnt_x[0];
            if (gnt_s[0])      ptr_s <= 2'd1;
            else if (gnt_s[1]) ptr_s <= 2'd2;
            else if (gnt_s[2]) ptr_s <= 2'd0;

            err_route <= n_gnt && (n_dx != my_x);
            err_self  <= p_sink;
        end
    end

endmodule

// File: tb/tb_torus_sw_alloc.sv
// tb/tb_torus_sw_alloc.sv - directed-vector bench for torus_sw_alloc
module tb_torus_sw_alloc;

    localparam int X_W = 3;
    localparam int Y_W = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [X_W-1:0] my_x;
    logic [Y_W-1:0] my_y;
    logic           w_vld, n_vld, p_vld;
    logic           w_tail, n_tail, p_tail;
    logic [X_W-1:0] w_dx, n_dx, p_dx;
    logic [Y_W-1:0] w_dy, n_dy, p_dy;
    logic           w_rdy, n_rdy, p_rdy;
    logic           e_rdy, s_rdy, x_rdy;
    logic           e_vld, s_vld, x_vld;
    logic           w2e, p2e, n2s, w2s, p2s, n2x, w2x;
    logic           err_route, err_self;

    torus_sw_alloc #(.X_W(X_W), .Y_W(Y_W)) dut (
        .clk(clk), .rst_n(rst_n), .my_x(my_x), .my_y(my_y),
        .w_vld(w_vld), .n_vld(n_vld), .p_vld(p_vld),
        .w_tail(w_tail), .n_tail(n_tail), .p_tail(p_tail),
        .w_dx(w_dx), .n_dx(n_dx), .p_dx(p_dx),
        .w_dy(w_dy), .n_dy(n_dy), .p_dy(p_dy),
        .w_rdy(w_rdy), .n_rdy(n_rdy), .p_rdy(p_rdy),
        .e_rdy(e_rdy), .s_rdy(s_rdy), .x_rdy(x_rdy),
        .e_vld(e_vld), .s_vld(s_vld), .x_vld(x_vld),
        .w2e(w2e), .p2e(p2e), .n2s(n2s), .w2s(w2s), .p2s(p2s), .n2x(n2x), .w2x(w2x),
        .err_route(err_route), .err_self(err_self)
    );

    always #5 clk = ~clk;

    // {w2e,p2e,n2s,w2s,p2s,n2x,w2x}
    logic [6:0] sels;
    assign sels = {w2e, p2e, n2s, w2s, p2s, n2x, w2x};

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    logic [6:0] s_order [3];

    initial begin
        s_order[0] = 7'b0010000;
        s_order[1] = 7'b0001000;
        s_order[2] = 7'b0000100;
        rst_n = 1'b0;
        my_x = 3'd2; my_y = 3'd3;
        w_vld = 0; n_vld = 0; p_vld = 0;
        w_tail = 0; n_tail = 0; p_tail = 0;
        w_dx = 0; n_dx = 0; p_dx = 0;
        w_dy = 0; n_dy = 0; p_dy = 0;
        e_rdy = 1; s_rdy = 1; x_rdy = 1;

        #12;
        check("rst_sel", 32'(sels), 0);
        check("rst_vld", 32'({e_vld, s_vld, x_vld}), 0);
        check("rst_rdy", 32'({w_rdy, n_rdy, p_rdy}), 0);
        check("rst_err", 32'({err_route, err_self}), 0);
        @(posedge clk); #1; rst_n = 1'b1;

        // W 3-flit packet east
        next_cyc(); w_vld = 1; w_tail = 0; w_dx = 3'd4; w_dy = 3'd0; #2;
        check("t1_c0_sel", 32'(sels), 0);
        check("t1_c0_wrdy", 32'(w_rdy), 0);
        for (int i = 1; i <= 3; i++) begin
            next_cyc(); w_tail = (i == 3); #2;
            check("t1_sel", 32'(sels), 32'h40);
            check("t1_wrdy", 32'(w_rdy), 1);
            check("t1_evld", 32'(e_vld), 1);
        end
        next_cyc(); w_vld = 0; w_tail = 0; #2;
        check("t1_c4_sel", 32'(sels), 0);
        check("t1_c4_evld", 32'(e_vld), 0);

        // W and N both eject: N first, W two cycles after N tail
        next_cyc();
        w_vld = 1; w_tail = 1; w_dx = 3'd2; w_dy = 3'd3;
        n_vld = 1; n_tail = 1; n_dx = 3'd2; n_dy = 3'd3; #2;
        check("t2_c0_sel", 32'(sels), 0);
        next_cyc(); #2;
        check("t2_c1_sel", 32'(sels), 32'h02);
        check("t2_c1_nrdy", 32'(n_rdy), 1);
        check("t2_c1_xvld", 32'(x_vld), 1);
        check("t2_c1_wrdy", 32'(w_rdy), 0);
        next_cyc(); n_vld = 0; n_tail = 0; #2;
        check("t2_c2_sel", 32'(sels), 0);
        check("t2_c2_wrdy", 32'(w_rdy), 0);
        next_cyc(); #2;
        check("t2_c3_sel", 32'(sels), 32'h01);
        check("t2_c3_wrdy", 32'(w_rdy), 1);
        check("t2_c3_xvld", 32'(x_vld), 1);
        next_cyc(); w_vld = 0; w_tail = 0; #2;
        check("t2_c4_sel", 32'(sels), 0);

        // N head with wrong X still ejects and pulses err_route
        next_cyc(); n_vld = 1; n_tail = 1; n_dx = 3'd3; n_dy = 3'd3; #2;
        check("er_c0_err", 32'(err_route), 0);
        next_cyc(); #2;
        check("er_c1_err", 32'(err_route), 1);
        check("er_c1_sel", 32'(sels), 32'h02);
        next_cyc(); n_vld = 0; n_tail = 0; #2;
        check("er_c2_err", 32'(err_route), 0);
        check("er_c2_sel", 32'(sels), 0);

        // Three-way round robin on south
        next_cyc();
        n_vld = 1; n_tail = 1; n_dx = 3'd2; n_dy = 3'd5;
        w_vld = 1; w_tail = 1; w_dx = 3'd2; w_dy = 3'd0;
        p_vld = 1; p_tail = 1; p_dx = 3'd2; p_dy = 3'd1; #2;
        check("t3_c0_sel", 32'(sels), 0);
        for (int i = 1; i <= 12; i++) begin
            next_cyc();
            if (i == 12) begin
                n_vld = 0; w_vld = 0; p_vld = 0;
            end
            #2;
            if (i % 2 == 1) begin
                check("t3_sel", 32'(sels), 32'(s_order[((i - 1) / 2) % 3]));
                check("t3_svld", 32'(s_vld), 1);
            end else begin
                check("t3_free", 32'(sels), 0);
            end
        end
        n_tail = 0; w_tail = 0; p_tail = 0;

        // PE packet to own tile is sunk
        next_cyc(); p_vld = 1; p_tail = 0; p_dx = 3'd2; p_dy = 3'd3; #2;
        check("t4_c0_prdy", 32'(p_rdy), 0);
        check("t4_c0_err", 32'(err_self), 0);
        next_cyc(); #2;
        check("t4_c1_err", 32'(err_self), 1);
        check("t4_c1_prdy", 32'(p_rdy), 1);
        check("t4_c1_vld", 32'({e_vld, s_vld, x_vld}), 0);
        check("t4_c1_sel", 32'(sels), 0);
        next_cyc(); p_tail = 1; #2;
        check("t4_c2_err", 32'(err_self), 0);
        check("t4_c2_prdy", 32'(p_rdy), 1);
        check("t4_c2_vld", 32'({e_vld, s_vld, x_vld}), 0);
        next_cyc(); p_vld = 0; p_tail = 0; #2;
        check("t4_c3_prdy", 32'(p_rdy), 0);

        // Downstream stall, then reset mid-packet
        next_cyc(); w_vld = 1; w_tail = 0; w_dx = 3'd5; w_dy = 3'd0; #2;
        check("t5_c0_wrdy", 32'(w_rdy), 0);
        next_cyc(); #2;
        check("t5_c1_wrdy", 32'(w_rdy), 1);
        check("t5_c1_sel", 32'(sels), 32'h40);
        for (int i = 0; i < 4; i++) begin
            next_cyc(); e_rdy = 0; #2;
            check("t5_stall_wrdy", 32'(w_rdy), 0);
            check("t5_stall_sel", 32'(sels), 32'h40);
            check("t5_stall_evld", 32'(e_vld), 1);
        end
        next_cyc(); e_rdy = 1; #2;
        check("t5_resume_wrdy", 32'(w_rdy), 1);
        check("t5_resume_sel", 32'(sels), 32'h40);
        next_cyc(); #1; rst_n = 0; #1;
        check("t5_rst_sel", 32'(sels), 0);
        check("t5_rst_wrdy", 32'(w_rdy), 0);
        check("t5_rst_evld", 32'(e_vld), 0);
        next_cyc(); rst_n = 1; w_vld = 1; w_tail = 1; w_dx = 3'd2; w_dy = 3'd0; #2;
        check("t5_head_sel", 32'(sels), 0);
        check("t5_head_wrdy", 32'(w_rdy), 0);
        next_cyc(); #2;
        check("t5_new_sel", 32'(sels), 32'h08);
        check("t5_new_wrdy", 32'(w_rdy), 1);
        check("t5_new_svld", 32'(s_vld), 1);
        next_cyc(); w_vld = 0; w_tail = 0; #2;
        check("t5_end_sel", 32'(sels), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
